// File: rtl/axi4_burst_memory__axi4_peripheral_pkg.sv
// Shared AXI4 types for the burst memory peripheral: burst/response encodings,
// address-step modes and the two channel FSM state sets.
package axi;

  typedef enum logic [2:0] {
    FIXED = 3'b001,
    INCR  = 3'b010,
    WRAP  = 3'b100
  } burst_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {STEP_FIXED, STEP_INCR, STEP_WRAP} step_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} write_state_t;

  typedef enum logic {R_IDLE, R_DATA} read_state_t;

  // WRAP is only defined for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_legal(input int unsigned len);
    return (len == 1) || (len == 3) || (len == 7) || (len == 15);
  endfunction

endpackage

// File: rtl/axi4_burst_memory__axi4_peripheral_addr.sv
// Per-channel burst address generator. addr is the address of the beat being
// transferred this cycle; on load it is the start address itself.
module axi4_burst_address_generator
  import axi::*;
#(
  parameter int ADDRESS_WIDTH = 4,
  parameter int LEN_WIDTH     = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load,
  input  logic                     advance,
  input  logic [ADDRESS_WIDTH-1:0] start,
  input  logic [LEN_WIDTH-1:0]     len,
  input  burst_t                   burst,
  output logic [ADDRESS_WIDTH-1:0] addr,
  output logic                     illegal
);

  logic [ADDRESS_WIDTH-1:0] cur, cur_mask, in_mask, eff_mask, step_addr;
  step_t                    cur_mode, in_mode, eff_mode;
  logic                     cur_illegal, in_illegal;

  always_comb begin
    in_mode    = STEP_FIXED;
    in_illegal = 1'b0;
    in_mask    = ADDRESS_WIDTH'(len);
    case (burst)
      FIXED: in_mode = STEP_FIXED;
      INCR:  in_mode = STEP_INCR;
      WRAP: begin
        if (wrap_len_legal(32'(len))) begin
          in_mode = STEP_WRAP;
        end else begin
          in_mode    = STEP_INCR;
          in_illegal = 1'b1;
        end
      end
      default: in_illegal = 1'b1;
    endcase
  end

  // A simultaneous load+advance yields the start address now and its successor next.
  always_comb begin
    addr     = load ? start      : cur;
    eff_mode = load ? in_mode    : cur_mode;
    eff_mask = load ? in_mask    : cur_mask;
    illegal  = load ? in_illegal : cur_illegal;
    case (eff_mode)
      STEP_INCR: step_addr = addr + 1'b1;
      STEP_WRAP: step_addr = (addr & ~eff_mask) | ((addr + 1'b1) & eff_mask);
      default:   step_addr = addr;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cur         <= '0;
      cur_mask    <= '0;
      cur_mode    <= STEP_FIXED;
      cur_illegal <= 1'b0;
    end else begin
      if (load) begin
        cur_mask    <= in_mask;
        cur_mode    <= in_mode;
        cur_illegal <= in_illegal;
      end
      if (load || advance) cur <= advance ? step_addr : addr;
    end
  end

endmodule

// File: rtl/axi4_burst_memory__axi4_peripheral.sv
// AXI4 burst memory peripheral: independent write and read channels, FIXED/INCR/WRAP
// bursts, byte strobes and sticky SLVERR per burst.
module axi4_burst_memory__axi4_peripheral
  import axi::*;
#(
  parameter int ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int LEN_WIDTH     = 8,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] awaddr,
  input  logic [LEN_WIDTH-1:0]     awlen,
  input  burst_t                   awburst,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [STRB_WIDTH-1:0]    wstrb,
  input  logic                     wlast,
  input  logic                     wvalid,
  output logic                     wready,
  output resp_t                    bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [ADDRESS_WIDTH-1:0] araddr,
  input  logic [LEN_WIDTH-1:0]     arlen,
  input  burst_t                   arburst,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [DATA_WIDTH-1:0]    rdata,
  output resp_t                    rresp,
  output logic                     rlast,
  output logic                     rvalid,
  input  logic                     rready
);

  logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];

  write_state_t             w_state, w_next;
  read_state_t              r_state, r_next;
  logic [LEN_WIDTH:0]       w_beat, r_beat;
  logic [LEN_WIDTH-1:0]     w_len, r_len;
  logic [ADDRESS_WIDTH-1:0] w_addr, r_addr;
  logic                     w_illegal, r_illegal, w_err;
  logic                     aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                     w_final, r_final, w_beat_err;

  assign aw_hs      = awvalid && awready;
  assign w_hs       = wvalid && wready;
  assign b_hs       = bvalid && bready;
  assign ar_hs      = arvalid && arready;
  assign r_hs       = rvalid && rready;
  assign w_final    = (w_beat == {1'b0, w_len});
  assign r_final    = (r_beat == {1'b0, r_len});
  assign w_beat_err = w_final ? !wlast : wlast;

  axi4_burst_address_generator #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .LEN_WIDTH(LEN_WIDTH)) u_aw_gen (
    .clock(clock), .reset(reset), .load(aw_hs), .advance(w_hs),
    .start(awaddr), .len(awlen), .burst(awburst), .addr(w_addr), .illegal(w_illegal)
  );

  // The read side advances at the AR handshake too: it always points at the word to fetch next.
  axi4_burst_address_generator #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .LEN_WIDTH(LEN_WIDTH)) u_ar_gen (
    .clock(clock), .reset(reset), .load(ar_hs), .advance(ar_hs || (r_hs && !r_final)),
    .start(araddr), .len(arlen), .burst(arburst), .addr(r_addr), .illegal(r_illegal)
  );

  always_ff @(posedge clock) begin
    if (!reset) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs)            w_next = W_DATA;
      W_DATA:  if (w_hs && w_final)  w_next = W_RESP;
      W_RESP:  if (b_hs)             w_next = W_IDLE;
      default:                       w_next = W_IDLE;
    endcase
  end

  always_comb begin
    awready = (w_state == W_IDLE);
    wready  = (w_state == W_DATA);
    bvalid  = (w_state == W_RESP);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      w_beat <= '0;
      w_len  <= '0;
      w_err  <= 1'b0;
      bresp  <= OKAY;
    end else begin
      if (aw_hs) begin
        w_len  <= awlen;
        w_beat <= '0;
        w_err  <= w_illegal;
      end
      if (w_hs) begin
        w_beat <= w_beat + 1'b1;
        if (w_final) bresp <= (w_err || w_beat_err) ? SLVERR : OKAY;
        else         w_err <= w_err || w_beat_err;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset && w_hs) begin
      for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
        if (wstrb[i]) mem[w_addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs)            r_next = R_DATA;
      R_DATA:  if (r_hs && r_final)  r_next = R_IDLE;
      default:                       r_next = R_IDLE;
    endcase
  end

  always_comb begin
    arready = (r_state == R_IDLE);
    rvalid  = (r_state == R_DATA);
  end

  // Reads sample mem before this edge's write lands, so same-address collisions are read-first.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rdata  <= '0;
      rlast  <= 1'b0;
      rresp  <= OKAY;
      r_beat <= '0;
      r_len  <= '0;
    end else if (ar_hs) begin
      rdata  <= mem[r_addr];
      rlast  <= (arlen == '0);
      rresp  <= r_illegal ? SLVERR : OKAY;
      r_beat <= '0;
      r_len  <= arlen;
    end else if (r_hs) begin
      if (r_final) begin
        rlast <= 1'b0;
      end else begin
        rdata  <= mem[r_addr];
        r_beat <= r_beat + 1'b1;
        rlast  <= ((r_beat + 1'b1) == {1'b0, r_len});
      end
    end
  end

endmodule

// File: tb/tb_axi4_burst_memory__axi4_peripheral.sv
// Randomised bench for the AXI4 burst memory, checked against a word-array model
// whose burst addresses are computed arithmetically from the start, length and type.
module tb_axi4_burst_memory__axi4_peripheral;
  import axi::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  awaddr, araddr;
  logic [7:0]  awlen, arlen;
  burst_t      awburst, arburst;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  resp_t       bresp, rresp;
  logic        arvalid, arready, rlast, rvalid, rready;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [16];
  logic [31:0] wbuf  [256];

  always #5 clock = ~clock;

  axi4_burst_memory__axi4_peripheral #(
    .ADDRESS_WIDTH(4), .DATA_WIDTH(32), .LEN_WIDTH(8)
  ) dut (
    .clock(clock), .reset(reset),
    .awaddr(awaddr), .awlen(awlen), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic wrap_ok(input int len);
    return (len + 1 == 2) || (len + 1 == 4) || (len + 1 == 8) || (len + 1 == 16);
  endfunction

  function automatic int beat_addr(input int start, input int len, input logic [2:0] burst, input int b);
    int size, base;
    size = len + 1;
    if (burst == WRAP && wrap_ok(len)) begin
      base = (start / size) * size;
      return base + ((start - base + b) % size);
    end
    if (burst == INCR || burst == WRAP) return (start + b) % 16;
    return start;
  endfunction

  function automatic logic burst_ok(input logic [2:0] burst, input int len);
    if (burst == FIXED || burst == INCR) return 1'b1;
    if (burst == WRAP) return wrap_ok(len);
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic axi_write(input int start, input int len, input logic [2:0] burst,
                           input int last_beat, input logic [3:0] strb, input string tag);
    int          cyc, a;
    logic        hs;
    logic [1:0]  got_resp, exp_resp;
    awaddr  = start[3:0];
    awlen   = len[7:0];
    awburst = burst_t'(burst);
    awvalid = 1'b1;
    cyc = 0; hs = 1'b0;
    while (!hs && cyc < 50) begin hs = awready; tick(); cyc++; end
    awvalid = 1'b0;
    if (!hs) begin check({tag, "_aw_timeout"}, 0, 1); return; end
    check({tag, "_aw_blocked"}, {63'd0, awready}, 0);
    for (int b = 0; b <= len; b++) begin
      if ($urandom_range(3) == 0) tick();
      wvalid = 1'b1;
      wdata  = wbuf[b];
      wstrb  = strb;
      wlast  = (b == last_beat);
      cyc = 0; hs = 1'b0;
      while (!hs && cyc < 50) begin hs = wready; tick(); cyc++; end
      wvalid = 1'b0;
      wlast  = 1'b0;
      if (!hs) begin check({tag, "_w_timeout"}, 0, 1); return; end
      a = beat_addr(start, len, burst, b);
      for (int i = 0; i < 4; i++) if (strb[i]) model[a][8*i +: 8] = wbuf[b][8*i +: 8];
    end
    check({tag, "_wready_off"}, {63'd0, wready}, 0);
    if ($urandom_range(1) == 0) tick();
    bready = 1'b1;
    cyc = 0; hs = 1'b0; got_resp = 2'b11;
    while (!hs && cyc < 50) begin hs = bvalid; got_resp = bresp; tick(); cyc++; end
    bready = 1'b0;
    if (!hs) begin check({tag, "_b_timeout"}, 0, 1); return; end
    exp_resp = (burst_ok(burst, len) && last_beat == len) ? 2'b00 : 2'b10;
    check({tag, "_bresp"}, {62'd0, got_resp}, {62'd0, exp_resp});
  endtask

  task automatic axi_read(input int start, input int len, input logic [2:0] burst,
                          input bit stall, input int abort_at, input string tag);
    int          cyc, b, budget;
    logic        hs, stalled;
    logic [31:0] held;
    logic [1:0]  exp_resp;
    exp_resp = burst_ok(burst, len) ? 2'b00 : 2'b10;
    araddr  = start[3:0];
    arlen   = len[7:0];
    arburst = burst_t'(burst);
    arvalid = 1'b1;
    cyc = 0; hs = 1'b0;
    while (!hs && cyc < 50) begin hs = arready; tick(); cyc++; end
    arvalid = 1'b0;
    if (!hs) begin check({tag, "_ar_timeout"}, 0, 1); return; end
    check({tag, "_first_valid"}, {63'd0, rvalid}, 1);
    b = 0; cyc = 0; stalled = 1'b0; held = '0;
    budget = 4 * (len + 1) + 20;
    while (b <= len && cyc < budget) begin
      rready = stall ? (cyc % 3 == 0) : 1'b1;
      if (stalled) check({tag, "_stable"}, {32'd0, rdata}, {32'd0, held});
      if (!rvalid) begin check({tag, "_valid"}, 0, 1); break; end
      if (b == abort_at) begin
        rready = 1'b0;
        reset  = 1'b0;
        tick();
        reset  = 1'b1;
        check({tag, "_abort_rvalid"}, {63'd0, rvalid}, 0);
        check({tag, "_abort_arready"}, {63'd0, arready}, 1);
        return;
      end
      if (rready) begin
        check({tag, "_rdata"}, {32'd0, rdata}, {32'd0, model[beat_addr(start, len, burst, b)]});
        check({tag, "_rlast"}, {63'd0, rlast}, {63'd0, (b == len)});
        check({tag, "_rresp"}, {62'd0, rresp}, {62'd0, exp_resp});
        b++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = rdata;
      end
      tick();
      cyc++;
    end
    rready = 1'b0;
    if (b <= len) check({tag, "_r_timeout"}, 0, 1);
    check({tag, "_r_done"}, {63'd0, rvalid}, 0);
    if (!stall) check({tag, "_r_cycles"}, 64'(cyc), 64'(len + 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1);
  end

  initial begin
    int s, l, lb, sel;
    logic [2:0] bt;
    reset = 1'b0;
    awaddr = '0; awlen = '0; awburst = INCR; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arlen = '0; arburst = INCR; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_awready", {63'd0, awready}, 1);
    check("rst_arready", {63'd0, arready}, 1);
    check("rst_wready",  {63'd0, wready}, 0);
    check("rst_bvalid",  {63'd0, bvalid}, 0);
    check("rst_rvalid",  {63'd0, rvalid}, 0);
    check("rst_rlast",   {63'd0, rlast}, 0);
    check("rst_rdata",   {32'd0, rdata}, 0);
    check("rst_resp",    {60'd0, bresp, rresp}, 0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 256; i++) wbuf[i] = $urandom;
    axi_write(0, 15, INCR, 15, 4'hF, "fill");
    axi_read(0, 15, INCR, 0, -1, "fill_rd");

    for (int i = 0; i < 4; i++) wbuf[i] = i;
    axi_write(14, 3, INCR, 3, 4'hF, "incr_wr");
    axi_read(14, 3, INCR, 0, -1, "incr_rd");

    wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC; wbuf[3] = 32'hD;
    axi_write(6, 3, WRAP, 3, 4'hF, "wrap_wr");
    axi_read(4, 3, INCR, 0, -1, "wrap_chk");
    axi_read(6, 3, WRAP, 0, -1, "wrap_rd");
    for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
    axi_write(6, 2, WRAP, 2, 4'hF, "wrap_bad_wr");
    axi_read(6, 2, INCR, 0, -1, "wrap_bad_chk");

    wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33;
    axi_write(3, 2, FIXED, 2, 4'hF, "fixed_wr");
    wbuf[0] = 32'hFFFF_FFFF;
    axi_write(3, 0, FIXED, 0, 4'b0101, "strb_wr");
    axi_read(3, 0, FIXED, 0, -1, "strb_rd");

    for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
    axi_write(8, 3, INCR, 1, 4'hF, "early_last");
    axi_write(8, 3, INCR, 3, 4'hF, "after_err");
    axi_write(9, 2, INCR, -1, 4'hF, "no_last");
    axi_read(8, 3, INCR, 0, -1, "err_rd");
    axi_write(2, 1, 3'b011, 1, 4'hF, "bad_burst_wr");
    axi_read(2, 1, 3'b000, 0, -1, "bad_burst_rd");

    axi_read(0, 7, INCR, 1, -1, "stall_rd");
    axi_read(0, 7, INCR, 1, 4, "abort_rd");
    axi_read(0, 7, INCR, 0, -1, "reread");

    for (int i = 0; i < 256; i++) wbuf[i] = $urandom;
    axi_write(5, 255, INCR, 255, 4'hF, "long_wr");
    axi_read(0, 15, INCR, 0, -1, "long_rd");

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
      s   = int'($urandom_range(15));
      l   = int'($urandom_range(15));
      sel = int'($urandom_range(3));
      bt  = (sel == 0) ? FIXED : (sel == 1) ? INCR : (sel == 2) ? WRAP : 3'b000;
      sel = int'($urandom_range(5));
      lb  = (sel == 0) ? -1 : (sel == 1) ? int'($urandom_range(l)) : l;
      axi_write(s, l, bt, lb, 4'($urandom), "rnd_wr");
      axi_read(s, l, bt, bit'($urandom_range(1)), -1, "rnd_rd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
